// File: rtl/p405s_dcu_tagram_pkg.sv
// Shared definitions for the parameterised data-cache tag RAM.
// Holds the flush-sequencer state encoding, the per-way entry field offsets
// and the helpers that derive entry width (EW) and word width (WW).
// Entry layout inside a way, LSB first: tag, valid, attr, parity.
package p405s_dcu_tagram_pkg;

    typedef enum logic [1:0] {
        FL_IDLE  = 2'd0,
        FL_CLEAR = 2'd1,
        FL_DONE  = 2'd2
    } flush_state_e;

    localparam int OFF_TAG = 0;

    function automatic int ew_f(input int tagw);
        return tagw + 3;
    endfunction

    function automatic int ww_f(input int ways, input int tagw);
        return ways * (tagw + 3);
    endfunction

    function automatic int off_valid_f(input int tagw);
        return tagw;
    endfunction

    function automatic int off_attr_f(input int tagw);
        return tagw + 1;
    endfunction

    function automatic int off_par_f(input int tagw);
        return tagw + 2;
    endfunction

endpackage

// File: rtl/p405s_dcu_tagram_core.sv
// Single-port synchronous tag array, DEPTH x WW, with per-bit write enable.
// Kept as its own module so a technology RAM macro can replace it.
// Ports:
//   clk    in  clock
//   cen_n  in  chip enable, active low
//   wen_n  in  per-bit write enable, active low
//   addr   in  word address
//   d      in  write data
//   q      out read data, registered; updated on every enabled access
module p405s_dcu_tagram_core #(
    parameter int DEPTH = 256,
    parameter int WW    = 48,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          cen_n,
    input  logic [WW-1:0] wen_n,
    input  logic [AW-1:0] addr,
    input  logic [WW-1:0] d,
    output logic [WW-1:0] q
);

    logic [WW-1:0] mem_q [DEPTH];
    logic [WW-1:0] q_q;

    // Read-first behaviour: q shows the word as it was before a write.
    always_ff @(posedge clk) begin
        if (!cen_n) begin
            mem_q[addr] <= (mem_q[addr] & wen_n) | (d & ~wen_n);
            q_q         <= mem_q[addr];
        end
    end

    assign q = q_q;

endmodule

// File: rtl/p405s_dcu_tagram_param.sv
// Data-cache tag RAM wrapper: functional read/write port with field-masked
// writes and parity, invalidate-all flush sequencer, and a BIST raw port.
// Ports:
//   cclk, rst_n                 clock, async active-low reset
//   rd_en, wr_en, addr          functional request and set index
//   way_we, fld_we              per-way and per-field {tag,valid,attr} write enables
//   wr_tag, wr_valid, wr_attr   write data
//   ready, rd_vld               request accepted / read data updated
//   rd_tag, rd_valid, rd_attr   last read result per way (way 0 in LSBs)
//   rd_par_err                  parity mismatch on a valid way
//   flush_req/busy/done         invalidate-all control
//   bist_*                      raw array access while bist_mode=1
//
// Flush FSM
//   state    | meaning
//   FL_IDLE  | functional port owns the array
//   FL_CLEAR | clearing valid bits, one set per cycle at cnt_q
//   FL_DONE  | one-cycle completion, flush_done=1
module p405s_dcu_tagram_param
    import p405s_dcu_tagram_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int DEPTH = 256,
    parameter int TAGW  = 21,
    localparam int AW   = $clog2(DEPTH),
    localparam int EW   = ew_f(TAGW),
    localparam int WW   = ww_f(WAYS, TAGW)
) (
    input  logic               cclk,
    input  logic               rst_n,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [AW-1:0]      addr,
    input  logic [WAYS-1:0]    way_we,
    input  logic [2:0]         fld_we,
    input  logic [TAGW-1:0]    wr_tag,
    input  logic               wr_valid,
    input  logic               wr_attr,
    output logic               ready,
    output logic               rd_vld,
    output logic [WAYS*TAGW-1:0] rd_tag,
    output logic [WAYS-1:0]    rd_valid,
    output logic [WAYS-1:0]    rd_attr,
    output logic [WAYS-1:0]    rd_par_err,
    input  logic               flush_req,
    output logic               flush_busy,
    output logic               flush_done,
    input  logic               bist_mode,
    input  logic               bist_ce_n,
    input  logic               bist_we_n,
    input  logic [AW-1:0]      bist_addr,
    input  logic [WW-1:0]      bist_wr_data,
    output logic [WW-1:0]      bist_rd_data
);

    localparam int OV = off_valid_f(TAGW);
    localparam int OA = off_attr_f(TAGW);
    localparam int OP = off_par_f(TAGW);

    flush_state_e  state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          init_q;
    logic          rd_vld_q;
    logic [WW-1:0] hold_q;
    logic [WW-1:0] rd_word;

    logic          ram_cen_n;
    logic [WW-1:0] ram_wen_n;
    logic [AW-1:0] ram_addr;
    logic [WW-1:0] ram_d;
    logic [WW-1:0] ram_q;

    logic          func_rd, func_wr;
    logic [EW-1:0] wr_entry;

    // init_q forces the automatic flush on the first cycle after reset and
    // keeps ready low until that flush has started.
    assign ready      = (state_q == FL_IDLE) && !init_q && !bist_mode;
    assign func_wr    = ready && wr_en;
    assign func_rd    = ready && rd_en && !wr_en;
    assign flush_busy = (state_q == FL_CLEAR) || (state_q == FL_DONE);
    assign flush_done = (state_q == FL_DONE);
    assign wr_entry   = {^wr_tag, wr_attr, wr_valid, wr_tag};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            FL_IDLE: begin
                if (init_q || flush_req) begin
                    state_d = FL_CLEAR;
                    cnt_d   = '0;
                end
            end
            FL_CLEAR: begin
                // BIST ownership freezes the sweep in place.
                if (!bist_mode) begin
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_d = FL_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            FL_DONE: state_d = FL_IDLE;
            default: state_d = FL_IDLE;
        endcase
    end

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FL_IDLE;
            cnt_q    <= '0;
            init_q   <= 1'b1;
            rd_vld_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            init_q   <= 1'b0;
            rd_vld_q <= func_rd;
            if (rd_vld_q) begin
                hold_q <= ram_q;
            end
        end
    end

    // Array port arbitration: BIST, then flush sweep, then functional port.
    always_comb begin
        ram_cen_n = 1'b1;
        ram_wen_n = '1;
        ram_addr  = addr;
        ram_d     = '0;
        if (bist_mode) begin
            ram_cen_n = bist_ce_n;
            ram_wen_n = {WW{bist_we_n}};
            ram_addr  = bist_addr;
            ram_d     = bist_wr_data;
        end else if (state_q == FL_CLEAR) begin
            ram_cen_n = 1'b0;
            ram_addr  = cnt_q;
            for (int w = 0; w < WAYS; w++) begin
                ram_wen_n[w*EW+OV] = 1'b0;
            end
        end else if (func_wr) begin
            ram_cen_n = 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                ram_d[w*EW +: EW] = wr_entry;
                if (way_we[w]) begin
                    if (fld_we[2]) begin
                        ram_wen_n[w*EW +: TAGW] = '0;
                        ram_wen_n[w*EW+OP]      = 1'b0;
                    end
                    if (fld_we[1]) ram_wen_n[w*EW+OV] = 1'b0;
                    if (fld_we[0]) ram_wen_n[w*EW+OA] = 1'b0;
                end
            end
        end else if (func_rd) begin
            ram_cen_n = 1'b0;
        end
    end

    p405s_dcu_tagram_core #(
        .DEPTH (DEPTH),
        .WW    (WW)
    ) u_core (
        .clk   (cclk),
        .cen_n (ram_cen_n),
        .wen_n (ram_wen_n),
        .addr  (ram_addr),
        .d     (ram_d),
        .q     (ram_q)
    );

    // The array output moves on every access; rd_* only follow it in the
    // cycle a functional read completes and otherwise show the held copy.
    assign rd_word      = rd_vld_q ? ram_q : hold_q;
    assign rd_vld       = rd_vld_q;
    assign bist_rd_data = ram_q;

    always_comb begin
        rd_tag     = '0;
        rd_valid   = '0;
        rd_attr    = '0;
        rd_par_err = '0;
        for (int w = 0; w < WAYS; w++) begin
            rd_tag[w*TAGW +: TAGW] = rd_word[w*EW+OFF_TAG +: TAGW];
            rd_valid[w]            = rd_word[w*EW+OV];
            rd_attr[w]             = rd_word[w*EW+OA];
            rd_par_err[w]          = rd_word[w*EW+OV] &
                                     (rd_word[w*EW+OP] ^ (^rd_word[w*EW +: TAGW]));
        end
    end

endmodule

// File: doc/p405s_dcu_tagram_param.md
P405S_DCU_TAGRAM_PARAM -- requirements
Module: p405s_dcu_tagram_param

Interface
REQ-001 The block SHALL have parameter WAYS, default 2, meaning the number of cache ways per set (1..4).
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning the number of sets (power of 2); AW = log2(DEPTH).
REQ-003 The block SHALL have parameter TAGW, default 21, meaning tag bits per way; EW = TAGW+3 (tag, valid, attr, parity); WW = WAYS*EW.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have these ports:
  cclk  in  1  clock;
  rst_n  in  1  asynchronous active-low reset;
  rd_en  in  1  functional read request;
  wr_en  in  1  functional write request;
  addr  in  AW  set index;
  way_we  in  WAYS  per-way write select;
  fld_we  in  3  field enables {tag,valid,attr}, shared by the selected ways;
  wr_tag  in  TAGW  write tag;
  wr_valid  in  1  write valid bit;
  wr_attr  in  1  write U0 attribute;
  ready  out  1  functional request accepted this cycle;
  rd_vld  out  1  read data updated this cycle;
  rd_tag  out  WAYS*TAGW  tag per way, way 0 in the LSBs;
  rd_valid  out  WAYS  valid per way;
  rd_attr  out  WAYS  U0 attribute per way;
  rd_par_err  out  WAYS  parity mismatch on a valid way;
  flush_req  in  1  invalidate-all request pulse;
  flush_busy  out  1  clear sequence active;
  flush_done  out  1  one-cycle completion pulse;
  bist_mode  in  1  BIST owns the array;
  bist_ce_n  in  1  BIST chip enable, active low;
  bist_we_n  in  1  BIST write enable, active low;
  bist_addr  in  AW  BIST address;
  bist_wr_data  in  WW  BIST raw word;
  bist_rd_data  out  WW  raw array output.

Function
REQ-006 The array SHALL be single-port and synchronous with per-bit write enable; a read SHALL return data the cycle after acceptance (rd_vld=1 in that cycle).
REQ-007 The rd_* outputs SHALL hold the last read result until the next accepted read completes; writes, flush and BIST SHALL NOT disturb them.
REQ-008 ready SHALL be 1 only when flush_busy=0 and bist_mode=0; while ready=0, rd_en and wr_en SHALL be ignored.
REQ-009 When rd_en and wr_en are both asserted, the write SHALL be performed and the read SHALL be dropped, with no rd_vld the next cycle.
REQ-010 A write SHALL update only the fields enabled by fld_we, and only in the ways enabled by way_we; all other bits SHALL be preserved.
REQ-011 The parity bit SHALL be the even parity of the tag; it SHALL be rewritten whenever the tag field is written.
REQ-012 rd_par_err[w] SHALL be 1 if and only if, for the returned entry of way w, valid=1 and the stored parity differs from the recomputed tag parity.
REQ-013 A read issued in the cycle after a write to the same address SHALL return the new data.
REQ-014 The flush state machine SHALL have three states: IDLE, CLEAR and DONE.
  - IDLE->CLEAR on flush_req, or on the first cycle after reset release.
  - In CLEAR, one set SHALL be written per cycle, addresses 0..DEPTH-1, clearing valid in all ways.
  - CLEAR->DONE after address DEPTH-1; DONE->IDLE after one cycle, with flush_done=1 in DONE.
REQ-015 flush_busy SHALL be 1 in CLEAR and DONE; a flush_req received while flush_busy=1 SHALL be ignored.
REQ-016 While bist_mode=1:
  - the bist_* ports SHALL drive the array;
  - a CLEAR sequence SHALL pause its address counter and resume at the same address when bist_mode=0.
REQ-017 bist_rd_data SHALL always reflect the raw array output word, way 0 in the LSBs, with entry order {parity, attr, valid, tag}.

Reset
REQ-018 While rst_n=0:
  - all rd_* outputs, rd_vld, ready and flush_done SHALL be 0;
  - flush_busy SHALL be 0;
  - the state SHALL be IDLE and the address counter 0.
REQ-019 Assertion of reset during CLEAR SHALL abort the sequence; the automatic flush after release SHALL restart it from address 0.
REQ-020 Array contents SHALL NOT be reset; validity is guaranteed only by the post-reset flush.

Structure
REQ-021 The package p405s_dcu_tagram_pkg SHALL hold the flush-state enumeration, the entry field offsets and the EW/WW derivation functions.
REQ-022 The memory SHALL be a sub-module p405s_dcu_tagram_core (DEPTH x WW, CEN/WEN active-low, per-bit WEN) so it can be swapped for a technology RAM.

Verification
REQ-023 The bench SHALL cover these directed scenarios (default parameters unless stated):
  - Post-reset: release rst_n -> flush_busy=1 for 257 cycles, flush_done pulses once, ready=1 next cycle, then a read of set 0x80 gives rd_valid=0.
  - Partial write: write tag 0x1ABCD, valid=1 to way 1 of set 5 with fld_we=3'b110, then read -> way 1 tag=0x1ABCD, valid=1, attr unchanged, way 0 untouched, rd_par_err=0.
  - Parity error: BIST write to set 7 flipping the way 0 parity bit with valid=1, then functional read -> rd_par_err=2'b01.
  - Hold and collision: read set 3 -> rd_vld pulse; then rd_en+wr_en to set 3 -> no rd_vld and rd_tag unchanged; a following read returns the new data.
  - BIST pause: assert bist_mode at clear address 100 for 20 cycles -> counter holds at 100; completion occurs 20 cycles later than normal.
  - Parameter sweep: WAYS=4, DEPTH=64, TAGW=18 -> flush takes 65 busy cycles, and way 3 writes are isolated from ways 0 to 2.
